uart_rx_fifo: RTL and testbench

- Hardware 8N1 UART receiver for the terminal-to-board direction, paired with the UART transmit side on the host link.
- Runs on clk_25M. Samples the serial rx pin with 16x oversampling and pushes good bytes into a small FIFO.
- Presents bytes to fabric logic (e.g. position or colour command decode) through a valid/ready handshake.
- Flags framing errors and FIFO overruns as single-cycle pulses.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/byte_fifo.sv | 64 ++++++
 rtl/uart_rx_fifo.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states, oversample ratio
// and the baud divider calculation.
package uart_pkg;

  // Samples taken per bit period.
  localparam int unsigned OVS = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } uart_state_e;

  // Clocks per oversample tick, truncated.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / (baud * OVS);
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small circular-buffer FIFO with first-word fall-through output.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   push, din    write request and data (dropped when full unless popping)
//   pop          read request (ignored when empty)
//   dout         entry at the head; reads 0 while empty
//   count        current occupancy
//   full, empty  occupancy flags
module byte_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push_c;
  logic             do_pop_c;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A pop frees the slot a same-cycle push into a full FIFO needs.
  assign do_pop_c  = pop && !empty;
  assign do_push_c = push && (!full || do_pop_c);

  assign dout = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop_c)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push_c, do_pop_c})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the output is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a byte FIFO.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   rx           asynchronous serial input, idles high
//   rx_data      byte at the FIFO head (valid while rx_valid)
//   rx_valid     FIFO non-empty
//   rx_ready     consumer accepts rx_data on rx_valid && rx_ready
//   fifo_count   FIFO occupancy
//   frame_err    one-cycle pulse: stop bit sampled low
//   overrun      one-cycle pulse: good byte arrived while FIFO full
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 25000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rx,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        frame_err,
  output logic                        overrun
);

  localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned TICK_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned SCNT_W   = $clog2(OVS);

  logic              rx_meta;
  logic              rx_s;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick_c;
  logic              start_c;

  uart_state_e       state_q, state_d;
  logic [SCNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              push_c;
  logic              frame_err_d;
  logic              overrun_d;
  logic              fifo_full;
  logic              fifo_empty;

  // Two-flop synchronizer; preset to the idle level.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Oversample tick; restarted on the start edge so ticks align to it.
  assign start_c = (state_q == IDLE) && !rx_s;
  assign tick_c  = (tick_cnt == TICK_W'(BAUD_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || start_c || tick_c) tick_cnt <= '0;
    else                            tick_cnt <= tick_cnt + 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      frame_err    <= frame_err_d;
      overrun      <= overrun_d;
    end
  end

  // Next-state logic: start bit checked at mid-bit, later bits every OVS ticks.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    push_c       = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d      = START;
          sample_cnt_d = '0;
        end
      end

      START: begin
        if (tick_c) begin
          if (sample_cnt_q == SCNT_W'(OVS / 2 - 1)) begin
            sample_cnt_d = '0;
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d   = DATA;
              bit_idx_d = '0;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (tick_c) begin
          if (sample_cnt_q == SCNT_W'(OVS - 1)) begin
            sample_cnt_d = '0;
            shift_d      = {rx_s, shift_q[7:1]};
            bit_idx_d    = bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) state_d = STOP;
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (tick_c) begin
          if (sample_cnt_q == SCNT_W'(OVS - 1)) begin
            sample_cnt_d = '0;
            if (rx_s) begin
              push_c  = 1'b1;
              state_d = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = BRK;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
        end
      end

      // Held-low line: wait for idle before hunting for a new start bit.
      BRK: begin
        if (rx_s) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Full FIFO drops the byte unless the consumer frees a slot this cycle.
  assign overrun_d = push_c && fifo_full && !(rx_ready && rx_valid);

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .pop   (rx_ready),
    .din   (shift_q),
    .dout  (rx_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a byte scoreboard and flag counters.
module tb_uart_rx_fifo;

  localparam int unsigned CLK_FREQ = 1600000;
  localparam int unsigned BAUD     = 10000;
  localparam int unsigned DEPTH    = 4;
  localparam int          BIT_CLKS = 160;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] fifo_count;
  logic       frame_err;
  logic       overrun;

  int vectors     = 0;
  int miscompares = 0;
  int fe_cnt      = 0;
  int ov_cnt      = 0;
  int acc_cnt     = 0;
  int fe0, ov0, acc0;

  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: sampled mid-cycle; a handshake seen here completes at the next edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        if (rx_valid && rx_ready) begin
          acc_cnt++;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_byte: got 0x%0h, expected none", rx_data);
          end else begin
            check("rx_data", int'(rx_data), int'(exp_q.pop_front()));
          end
        end
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (frame_err || overrun)
          check("flags_exclusive", int'(frame_err && overrun), 0);
      end
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Drives one 8N1 frame; call right after a negedge.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = stop;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b, input logic expect_it);
    if (expect_it) exp_q.push_back(b);
    send_frame(b, 1'b1);
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 200 && fifo_count != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check(name, int'(fifo_count), 0);
  endtask

  task automatic mark();
    fe0  = fe_cnt;
    ov0  = ov_cnt;
    acc0 = acc_cnt;
  endtask

  initial begin
    reset    = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", int'(rx_valid), 0);
    check("reset_data", int'(rx_data), 0);
    check("reset_count", int'(fifo_count), 0);
    check("reset_flags", int'({frame_err, overrun}), 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // 1: two bytes straight through
    mark();
    rx_ready = 1'b1;
    send_good(8'h41, 1'b1);
    send_good(8'hA5, 1'b1);
    wait_empty("t1_count");
    check("t1_accepted", acc_cnt - acc0, 2);
    check("t1_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    // 2: fill, overrun on the fifth byte, then drain
    mark();
    rx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_good(8'(i), 1'b1);
    check("t2_full_count", int'(fifo_count), 4);
    check("t2_no_overrun_yet", ov_cnt - ov0, 0);
    send_good(8'h05, 1'b0);
    check("t2_overrun", ov_cnt - ov0, 1);
    check("t2_count_after_ovr", int'(fifo_count), 4);
    check("t2_head", int'(rx_data), 8'h01);
    rx_ready = 1'b1;
    wait_empty("t2_drain");
    check("t2_accepted", acc_cnt - acc0, 4);
    check("t2_frame_err", fe_cnt - fe0, 0);

    // 3: short low glitch rejected, next byte fine
    mark();
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (1600) @(negedge clk);
    check("t3_glitch_accepted", acc_cnt - acc0, 0);
    check("t3_glitch_fe", fe_cnt - fe0, 0);
    check("t3_glitch_count", int'(fifo_count), 0);
    send_good(8'h5A, 1'b1);
    wait_empty("t3_count");
    check("t3_accepted", acc_cnt - acc0, 1);

    // 4: framing error then held break
    mark();
    send_frame(8'h33, 1'b0);
    rx = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    check("t4_frame_err", fe_cnt - fe0, 1);
    check("t4_no_bytes", acc_cnt - acc0, 0);
    check("t4_count", int'(fifo_count), 0);
    send_good(8'hC3, 1'b1);
    wait_empty("t4_count_after");
    check("t4_accepted", acc_cnt - acc0, 1);
    check("t4_frame_err_total", fe_cnt - fe0, 1);

    // 5: reset during data bit 4 empties FIFO and drops the partial byte
    mark();
    rx_ready = 1'b0;
    send_good(8'h99, 1'b1);
    check("t5_pre_count", int'(fifo_count), 1);
    fork
      send_frame(8'hF5, 1'b1);
      begin
        repeat (5 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
      end
    join
    repeat (20) @(negedge clk);
    check("t5_count", int'(fifo_count), 0);
    check("t5_valid", int'(rx_valid), 0);
    check("t5_data", int'(rx_data), 0);
    rx_ready = 1'b1;
    send_good(8'h7E, 1'b1);
    wait_empty("t5_count_after");
    check("t5_accepted", acc_cnt - acc0, 1);

    // 6: push and pop in the same cycle at count 3
    mark();
    rx_ready = 1'b0;
    send_good(8'h21, 1'b1);
    send_good(8'h22, 1'b1);
    send_good(8'h23, 1'b1);
    check("t6_count3", int'(fifo_count), 3);
    exp_q.push_back(8'h10);
    fork
      send_frame(8'h10, 1'b1);
      begin
        // push lands on the 1523rd rising edge after the start edge
        repeat (1522) @(posedge clk);
        @(negedge clk);
        check("t6_pre_push_count", int'(fifo_count), 3);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("t6_same_cycle_count", int'(fifo_count), 3);
      end
    join
    repeat (20) @(negedge clk);
    check("t6_count_hold", int'(fifo_count), 3);
    check("t6_head", int'(rx_data), 8'h22);
    check("t6_accepted", acc_cnt - acc0, 1);
    check("t6_overrun", ov_cnt - ov0, 0);
    rx_ready = 1'b1;
    wait_empty("t6_drain");
    check("t6_accepted_total", acc_cnt - acc0, 4);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
